// File: rtl/cond_pkg.sv
// Shared constants for the conditional-execution stage: ARM condition codes
// and the bit positions of the NZCV flags and the FlagW write groups.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam int unsigned FLAGW_NZ = 1;
    localparam int unsigned FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluator: pass is high when the 4-bit
// condition holds for the given {N,Z,C,V} flags.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_pass
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = ~w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = ~w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = ~w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = ~w_v;
            COND_HI: o_pass = w_c & ~w_z;
            COND_LS: o_pass = ~w_c | w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = ~w_z & (w_n == w_v);
            COND_LE: o_pass = w_z | (w_n != w_v);
            COND_AL: o_pass = 1'b1;
            COND_NV: o_pass = 1'b0;
            default: o_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution stage: NZCV flag register, condition check and
// squash-qualified write enables. Define COND_PERF_CNT_EN to build the
// executed/squashed instruction counters; otherwise both ports read 0.
module cond_unit
    import cond_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             flag_load,
    input  logic [3:0]       flag_data,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    logic [3:0] r_flags;
    logic       w_pass;
    logic       w_condex;

    cond_check u_cond_check (
        .i_cond  (Cond),
        .i_flags (r_flags),
        .o_pass  (w_pass)
    );

    // Reset gates the enables so nothing downstream commits during reset.
    assign w_condex = in_valid & w_pass & ~reset;

    assign CondEx   = w_condex;
    assign PCSrc    = PCS  & w_condex;
    assign RegWrite = RegW & w_condex;
    assign MemWrite = MemW & w_condex;
    assign Flags    = r_flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
        end else if (flag_load) begin
            r_flags <= flag_data;
        end else begin
            if (FlagW[FLAGW_NZ] & w_condex)
                r_flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
            if (FlagW[FLAGW_CV] & w_condex)
                r_flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
        end
    end

`ifdef COND_PERF_CNT_EN
    logic [CNT_W-1:0] r_exec_cnt;
    logic [CNT_W-1:0] r_squash_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_exec_cnt   <= '0;
            r_squash_cnt <= '0;
        end else if (in_valid) begin
            if (w_condex) begin
                if (r_exec_cnt != '1)
                    r_exec_cnt <= r_exec_cnt + 1'b1;
            end else begin
                if (r_squash_cnt != '1)
                    r_squash_cnt <= r_squash_cnt + 1'b1;
            end
        end
    end

    assign exec_cnt   = r_exec_cnt;
    assign squash_cnt = r_squash_cnt;
`else
    assign exec_cnt   = '0;
    assign squash_cnt = '0;
`endif

endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution stage that consumes the decoder's control outputs (FlagW, PCS, RegW, MemW) together with the instruction's condition field and the ALU's flags. It holds the architectural NZCV flag register, evaluates the 4-bit ARM condition code against the registered flags, and produces the final, squash-qualified write enables PCSrc, RegWrite and MemWrite for the datapath.

## Interface
Parameters:
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  current instruction is real; low means bubble.
- Cond  input  4  instruction bits [31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction.
- FlagW  input  2  from decoder; [1] writes N,Z and [0] writes C,V.
- PCS  input  1  from decoder; PC-write request.
- RegW  input  1  from decoder; register-write request.
- MemW  input  1  from decoder; memory-write request.
- flag_load  input  1  direct flag load (MSR-style).
- flag_data  input  4  {N,Z,C,V} value for flag_load.
- PCSrc  output  1  qualified PC write.
- RegWrite  output  1  qualified register write.
- MemWrite  output  1  qualified memory write.
- CondEx  output  1  condition passed and in_valid high.
- Flags  output  4  registered {N,Z,C,V}.
- exec_cnt  output  CNT_W  count of executed instructions.
- squash_cnt  output  CNT_W  count of squashed instructions.

## Operation
- The condition is evaluated against the registered Flags, never against ALUFlags.
- Condition codes: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0.
- CondEx = in_valid & condition passed. PCSrc = PCS&CondEx, RegWrite = RegW&CondEx, MemWrite = MemW&CondEx.
- Flag write: Flags[3:2] <= ALUFlags[3:2] when FlagW[1]&CondEx; Flags[1:0] <= ALUFlags[1:0] when FlagW[0]&CondEx. Groups are independent; an unwritten group holds its value.
- flag_load has priority: Flags <= flag_data in full, ignoring FlagW in the same cycle. flag_load does not depend on in_valid.
- Counters, when enabled: an in_valid cycle increments exec_cnt if CondEx is 1, otherwise squash_cnt. Both saturate at all-ones and do not wrap.

## Timing
- PCSrc, RegWrite, MemWrite and CondEx are combinational from the inputs and the registered Flags, with zero-cycle latency.
- A flag update becomes visible on Flags, and to the condition check, on the cycle after the setting instruction.
- Reset, sampled at the edge: Flags=4'b0000, exec_cnt=0, squash_cnt=0. While reset is high, PCSrc, RegWrite, MemWrite and CondEx are forced to 0 and no flag or counter update occurs.
- Reset asserted mid-stream overrides flag_load and FlagW in that cycle.
- When in_valid is low, all qualified outputs are 0, flags hold (unless flag_load is high) and counters hold.

## Configuration
- COND_PERF_CNT_EN defined: exec_cnt and squash_cnt are implemented as described above.
- COND_PERF_CNT_EN undefined: no counter flops are built. Both ports remain present and are tied to 0.
- All other behaviour is identical in both builds.

## Structure
- Shared package cond_pkg holds:
  - localparams COND_EQ through COND_NV (4-bit);
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - FlagW group indices FLAGW_NZ=1, FLAGW_CV=0.
- One sub-module, cond_check: purely combinational, taking Cond[3:0] and Flags[3:0] and producing a 1-bit pass. It is reused by any later pipelined variant.
- The flag register and counters live in cond_unit.

## Test plan
- Reset, then Cond=1110, RegW=1, in_valid=1 -> RegWrite=1, Flags=0000. Then Cond=0000 -> RegWrite=0.
- Issue SUBS 5-5 (ALUFlags=0110, FlagW=11, Cond=1110), then next cycle Cond=0000, PCS=1 -> Flags=0110 and PCSrc=1 in the second cycle, not the first.
- FlagW=10 with ALUFlags=1001 from Flags=0110 -> Flags=1010, with C and V preserved.
- flag_load=1, flag_data=0001 together with FlagW=11, ALUFlags=1110 -> Flags=0001. Then Cond=0110 (VS) with MemW=1 -> MemWrite=1.
- Cond=1111 with PCS=1, RegW=1, MemW=1, in_valid=1 -> all qualified outputs 0; with COND_PERF_CNT_EN, squash_cnt increments by 1.
- With COND_PERF_CNT_EN and CNT_W=4, apply 17 executed instructions -> exec_cnt=4'hF and holds. Then assert reset -> exec_cnt=0 and Flags=0000 at the next edge.
